// File: rtl/if_stage.sv
// if_stage: instruction fetch stage.
// Holds the PC and issues one word-aligned read at a time to instruction
// memory over a req/gnt/rvalid bus. Delivers {instruction, pc} to decode
// through a single-entry valid/ready output register. Accepts redirects
// from execute and discards any response that was in flight when the
// redirect happened.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   imem_req_o/addr_o      fetch request and word-aligned byte address
//   imem_gnt_i             request accepted (req & gnt)
//   imem_rvalid_i/rdata_i  read response, one per grant, in order
//   br_taken_i/target_i    redirect pulse and target (bits [1:0] ignored)
//   instr_valid_o          instruction_o/pc_o hold an unconsumed instruction
//   instruction_o, pc_o    fetched word and its address
//   id_ready_i             decode accepts when instr_valid_o & id_ready_i
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  output logic        instr_valid_o,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  input  logic        id_ready_i
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_WAIT
  } state_e;

  state_e      state_q, state_d;
  // Word address only; the byte offset is always zero.
  logic [29:0] pc_q;
  logic        drop_q, drop_d;
  logic        buf_free;
  logic        grant;
  logic        resp;
  logic        load;

  // Target byte offset is discarded on purpose (silent alignment).
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^br_target_i[1:0];

  // Only request when the output register can take the response, so a
  // response never arrives to a full register.
  always_comb begin
    buf_free = !instr_valid_o || id_ready_i;
    grant    = imem_req_o && imem_gnt_i;
    resp     = (state_q == S_WAIT) && imem_rvalid_i;
    load     = resp && !drop_q && !br_taken_i;
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ:  if (grant) state_d = S_WAIT;
      S_WAIT: if (imem_rvalid_i) state_d = S_REQ;
      default: state_d = S_BOOT;
    endcase
  end

  // Output logic
  always_comb begin
    imem_req_o  = (state_q == S_REQ) && buf_free;
    imem_addr_o = {pc_q, 2'b00};
  end

  // A redirect marks whatever is (or is becoming) outstanding as stale; a
  // response arriving in the redirect cycle itself is dropped directly.
  always_comb begin
    drop_d = drop_q;
    if (br_taken_i) begin
      if (grant) begin
        drop_d = 1'b1;
      end else if (state_q == S_WAIT) begin
        drop_d = !imem_rvalid_i;
      end
    end else if (resp) begin
      drop_d = 1'b0;
    end
  end

  // PC, drop flag and decode-facing output register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q          <= RESET_PC[31:2];
      drop_q        <= 1'b0;
      instr_valid_o <= 1'b0;
      instruction_o <= NOP_INSN;
      pc_o          <= RESET_PC;
    end else begin
      drop_q <= drop_d;

      if (br_taken_i) begin
        pc_q <= br_target_i[31:2];
      end else if (load) begin
        pc_q <= pc_q + 30'd1;
      end

      if (br_taken_i) begin
        instr_valid_o <= 1'b0;
        instruction_o <= NOP_INSN;
      end else if (load) begin
        instr_valid_o <= 1'b1;
        instruction_o <= imem_rdata_i;
        pc_o          <= {pc_q, 2'b00};
      end else if (instr_valid_o && id_ready_i) begin
        instr_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios with literal expectations, then
// randomized bus/decode/redirect traffic checked each cycle against a
// transaction-level model (outstanding flag + stale flag + output slot).
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        br_taken_i = 1'b0;
  logic [31:0] br_target_i = '0;
  logic        instr_valid_o;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;
  logic        id_ready_i = 1'b0;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RESET_PC), .NOP_INSN(NOP)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .br_taken_i    (br_taken_i),
    .br_target_i   (br_target_i),
    .instr_valid_o (instr_valid_o),
    .instruction_o (instruction_o),
    .pc_o          (pc_o),
    .id_ready_i    (id_ready_i)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pco;
  bit          m_valid, m_out, m_stale, m_run;

  // Memory responder state
  bit          mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat_min = 1, lat_max = 1;

  // Transaction logs
  logic [31:0] g_addr[$];
  int          g_cyc[$];
  logic [31:0] d_pc[$];
  logic [31:0] d_ins[$];
  int          cyc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_instr = NOP; m_pco = RESET_PC;
    m_valid = 0; m_out = 0; m_stale = 0; m_run = 0;
  endtask

  // One clock: check at negedge, log, predict; drive memory after posedge.
  task automatic cycle();
    bit          exp_req, grant_m, resp_m, s_grant;
    logic [31:0] s_addr, n_pc, n_instr, n_pco;
    bit          n_valid, n_out, n_stale;
    @(negedge clk);
    exp_req = m_run && !m_out && (!m_valid || id_ready_i);
    chk("req", {31'd0, imem_req_o}, {31'd0, exp_req});
    if (exp_req) chk("addr", imem_addr_o, m_pc);
    chk("valid", {31'd0, instr_valid_o}, {31'd0, m_valid});
    chk("instr", instruction_o, m_instr);
    chk("pc_o", pc_o, m_pco);
    s_grant = imem_req_o && imem_gnt_i;
    s_addr  = imem_addr_o;
    if (s_grant) begin g_addr.push_back(s_addr); g_cyc.push_back(cyc); end
    if (instr_valid_o && id_ready_i) begin d_pc.push_back(pc_o); d_ins.push_back(instruction_o); end

    n_pc = m_pc; n_instr = m_instr; n_pco = m_pco;
    n_valid = m_valid; n_out = m_out; n_stale = m_stale;
    grant_m = exp_req && imem_gnt_i;
    resp_m  = m_out && imem_rvalid_i;
    if (br_taken_i) begin
      n_pc = br_target_i & 32'hFFFF_FFFC;
      n_valid = 0; n_instr = NOP;
      if (grant_m) begin n_out = 1; n_stale = 1; end
      else if (resp_m) begin n_out = 0; n_stale = 0; end
      else if (m_out) n_stale = 1;
    end else begin
      if (m_valid && id_ready_i) n_valid = 0;
      if (grant_m) n_out = 1;
      if (resp_m) begin
        n_out = 0;
        if (!m_stale) begin
          n_instr = imem_rdata_i; n_pco = m_pc; n_valid = 1; n_pc = m_pc + 32'd4;
        end
        n_stale = 0;
      end
    end

    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_pco = n_pco;
    m_valid = n_valid; m_out = n_out; m_stale = n_stale; m_run = 1;
    cyc++;
    if (s_grant) begin
      mem_pend = 1; mem_cnt = $urandom_range(lat_max, lat_min); mem_addr = s_addr;
    end
    imem_rvalid_i = 0;
    imem_rdata_i  = $urandom;
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid_i = 1; imem_rdata_i = mem_word(mem_addr); mem_pend = 0;
      end
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    imem_rvalid_i = 0;
    mem_pend = 0;
    #1;
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_instr", instruction_o, 32'h0000_0013);
    chk("rst_pc_o", pc_o, 32'h0000_0000);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    g_addr.delete(); g_cyc.delete(); d_pc.delete(); d_ins.delete();
    cyc = 0;
  endtask

  initial begin
    logic [31:0] exp_g [10];
    logic [31:0] exp_d [6];
    logic [31:0] exp_w [3];

    @(posedge clk); #1;
    do_reset();

    // Streaming fetch, stall, and the three redirect cases
    imem_gnt_i = 1; id_ready_i = 1; br_taken_i = 0;
    repeat (7) cycle();
    id_ready_i = 0;
    repeat (5) cycle();
    chk("stall_grants", g_addr.size(), 32'd3);
    chk("stall_valid", {31'd0, instr_valid_o}, 32'd1);
    chk("stall_pc_o", pc_o, 32'h8);
    id_ready_i = 1; lat_min = 3; lat_max = 3;
    cycle();
    lat_min = 1; lat_max = 1;
    br_taken_i = 1; br_target_i = 32'h0000_0102;
    cycle();
    br_taken_i = 0;
    repeat (4) cycle();
    br_taken_i = 1; br_target_i = 32'h0000_0040;
    cycle();
    br_taken_i = 0;
    repeat (4) cycle();
    br_taken_i = 1; br_target_i = 32'h0000_0083;
    cycle();
    br_taken_i = 0;
    chk("rv_br_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rv_br_instr", instruction_o, 32'h0000_0013);
    repeat (2) cycle();
    lat_min = 3; lat_max = 3;
    cycle();
    lat_min = 1; lat_max = 1;

    exp_g = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h104, 32'h40, 32'h44, 32'h80, 32'h84};
    exp_d = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h40, 32'h80};
    chk("grant_count", g_addr.size(), 32'd10);
    for (int i = 0; i < 10; i++)
      chk("grant_addr", (i < g_addr.size()) ? g_addr[i] : 32'hDEAD_BEEF, exp_g[i]);
    chk("deliv_count", d_pc.size(), 32'd6);
    for (int i = 0; i < 6; i++)
      chk("deliv_pc", (i < d_pc.size()) ? d_pc[i] : 32'hDEAD_BEEF, exp_d[i]);
    chk("deliv_ins0", (d_ins.size() > 0) ? d_ins[0] : 32'hDEAD_BEEF, 32'hC0DE_0000);
    chk("deliv_ins3", (d_ins.size() > 3) ? d_ins[3] : 32'hDEAD_BEEF, 32'hC0DE_0100);
    chk("first_grant_cyc", (g_cyc.size() > 0) ? g_cyc[0] : -1, 32'd1);
    chk("grant_spacing1", (g_cyc.size() > 1) ? g_cyc[1] - g_cyc[0] : -1, 32'd2);
    chk("grant_spacing2", (g_cyc.size() > 2) ? g_cyc[2] - g_cyc[1] : -1, 32'd2);

    // Reset while a response is outstanding, then PC wrap via redirect
    do_reset();
    cycle();
    br_taken_i = 1; br_target_i = 32'hFFFF_FFFE;
    cycle();
    br_taken_i = 0;
    repeat (5) cycle();
    exp_w = '{32'h0, 32'hFFFF_FFFC, 32'h0};
    chk("wrap_count", g_addr.size(), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("wrap_grant", (i < g_addr.size()) ? g_addr[i] : 32'hDEAD_BEEF, exp_w[i]);
    chk("wrap_deliv", (d_pc.size() > 0) ? d_pc[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    chk("wrap_first_cyc", (g_cyc.size() > 0) ? g_cyc[0] : -1, 32'd1);

    // Randomized traffic
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 4000; i++) begin
      imem_gnt_i  = ($urandom % 4) != 0;
      id_ready_i  = ($urandom % 4) != 0;
      br_taken_i  = ($urandom % 12) == 0;
      br_target_i = $urandom;
      if (($urandom % 600) == 0) begin
        br_taken_i = 0;
        do_reset();
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction fetch stage: producer side of the 32-bit instruction word consumed by the decode stage.
- Holds the PC and issues one word-aligned read at a time to instruction memory over a req/gnt/rvalid bus.
- Delivers {instruction, pc} to decode through a single-entry valid/ready output register.
- Takes branch/jump redirects from execute and discards stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
NOP_INSN, 32'h0000_0013, value of instruction_o at reset and after a redirect flush (addi x0,x0,0)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_ni  input  1  asynchronous active-low reset
imem_req_o  output  1  fetch request valid
imem_addr_o  output  32  fetch byte address, bits [1:0] always 0
imem_gnt_i  input  1  request accepted this cycle (req & gnt)
imem_rvalid_i  input  1  read data valid; exactly one per grant, in order, at least 1 cycle after grant
imem_rdata_i  input  32  instruction word
br_taken_i  input  1  redirect pulse from execute
br_target_i  input  32  redirect target; bits [1:0] ignored
instr_valid_o  output  1  instruction_o/pc_o hold an unconsumed instruction
instruction_o  output  32  fetched instruction to decode
pc_o  output  32  address of instruction_o
id_ready_i  input  1  decode accepts; transfer when instr_valid_o & id_ready_i

Behaviour:
- Reset (rst_ni low, asynchronous):
  - pc = RESET_PC, state = S_BOOT, drop = 0, instr_valid_o = 0.
  - instruction_o = NOP_INSN, pc_o = RESET_PC.
  - imem_req_o = 0 while rst_ni is low.
  - Reset mid-transaction abandons any outstanding response; the memory side is reset in the same domain.
- States:
  - S_BOOT: no request; next cycle goes to S_REQ.
  - S_REQ: imem_req_o = buf_free, where buf_free = !instr_valid_o | id_ready_i (combinational). imem_addr_o = {pc[31:2],2'b00}. On req & gnt, go to S_WAIT.
  - S_WAIT: imem_req_o = 0; at most one outstanding request. On imem_rvalid_i:
    - if drop = 1: discard the data, clear drop.
    - else: load instruction_o = rdata, pc_o = pc, set instr_valid_o, pc = pc + 4 (32-bit wrap, 0xFFFF_FFFC -> 0x0000_0000).
    - In both cases go to S_REQ.
- Output register:
  - Cleared (instr_valid_o = 0) when consumed and not reloaded in the same cycle.
  - Contents stay stable while instr_valid_o & !id_ready_i.
  - Since a request issues only when buf_free, a response never finds the register full.
- Throughput: with gnt in the req cycle and rvalid the next cycle, one instruction every 2 cycles.
- Latency: first imem_req_o is 1 cycle after reset release. instr_valid_o rises 1 cycle after rvalid.
- Redirect (br_taken_i = 1), highest priority, all effects in the same edge:
  - pc = {br_target_i[31:2],2'b00}.
  - instr_valid_o = 0, instruction_o = NOP_INSN. A same-cycle decode handshake still counts as consumed.
  - In S_REQ without gnt: stay in S_REQ; the address changes to the target next cycle. The address may change before grant.
  - In S_REQ with gnt: go to S_WAIT with drop = 1.
  - In S_WAIT without rvalid: drop = 1.
  - In S_WAIT with rvalid: discard the response, go to S_REQ, drop = 0.
  - In S_BOOT: pc updated, go to S_REQ.
- A redirect in the same cycle as a normal rvalid load: the redirect wins and the load is suppressed.
- Misaligned targets are silently aligned; no trap is generated.

Test Plan:
- Reset release, gnt tied 1, rvalid 1 cycle after grant, id_ready_i = 1 -> req at 0x0, 0x4, 0x8 every 2 cycles. instr_valid_o pulses carry matching rdata and pc_o = 0x0, 0x4, 0x8.
- Decode stall: id_ready_i = 0 for 5 cycles after first instruction -> instruction_o/pc_o = 0x0 stable, imem_req_o = 0 throughout. Fetch of 0x4 is requested in the cycle id_ready_i returns to 1.
- Redirect during S_WAIT to 0x0000_0102 -> in-flight response for 0x8 discarded (never valid). Next req addr = 0x0000_0100, then pc_o = 0x100 delivered.
- Redirect coincident with req&gnt at 0xC, target 0x40 -> response for 0xC dropped. Following request addr 0x40, no NOP or stale instruction with valid set.
- Redirect coincident with rvalid and with instr_valid_o & id_ready_i -> output invalid next cycle, instruction_o = 0x0000_0013. The response is dropped; next req addr = target.
- Assert rst_ni low while in S_WAIT, then release -> outputs at reset values. After 1 cycle, req at RESET_PC.
